// File: rtl/isqrt_iter_if.sv
// Argument/result channel between a formula FSM and one isqrt_iter unit.
// Latency: none; this is a plain bundle of wires.
// Backpressure: none; the requester may issue only when busy is low.
interface isqrt_iter_if;
    logic        x_vld;
    logic [31:0] x;
    logic        y_vld;
    logic [15:0] y;
    logic        busy;

    // Requester side (the formula FSM).
    modport master (
        output x_vld,
        output x,
        input  y_vld,
        input  y,
        input  busy
    );

    // Square-root unit side.
    modport slave (
        input  x_vld,
        input  x,
        output y_vld,
        output y,
        output busy
    );
endinterface

// File: rtl/isqrt_iter.sv
// Iterative restoring integer square root: y = floor(sqrt(x)), one root bit per clock.
// Latency: fixed 17 cycles from accept to the y_vld pulse; a new accept is allowed in the y_vld cycle.
// Backpressure: none; x_vld arriving while busy is dropped silently.
module isqrt_iter (
    input  logic         clk,
    input  logic         rst,
    isqrt_iter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] xs_q,    xs_d;
    logic [17:0] rem_q,   rem_d;
    logic [15:0] root_q,  root_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [15:0] y_q,     y_d;
    logic        y_vld_q, y_vld_d;
    logic        busy_q,  busy_d;

    // Single-iteration datapath terms.
    logic [17:0] t;
    logic [17:0] trial;
    logic [17:0] rem_nx;
    logic [15:0] root_nx;

    // Next-state, datapath iteration and registered output decode.
    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        y_d     = y_q;

        // Bring down the next two radicand bits and try appending a 1 to the root.
        t     = {rem_q[15:0], xs_q[31:30]};
        trial = {root_q, 2'b01};
        if (t >= trial) begin
            rem_nx  = t - trial;
            root_nx = {root_q[14:0], 1'b1};
        end else begin
            rem_nx  = t;
            root_nx = {root_q[14:0], 1'b0};
        end

        case (state_q)
            // DONE accepts exactly like IDLE so dependent roots can chain without a gap.
            IDLE, DONE: begin
                if (bus.x_vld) begin
                    xs_d    = bus.x;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                xs_d   = {xs_q[29:0], 2'b00};
                rem_d  = rem_nx;
                root_d = root_nx;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    y_d     = root_nx;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        y_vld_d = (state_q == CALC) && (cnt_q == 4'd15);
        busy_d  = (state_d == CALC);
    end

    // State and datapath registers; reset wins over any accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            xs_q    <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            y_vld_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.y_vld = y_vld_q;
    assign bus.y     = y_q;
    assign bus.busy  = busy_q;

endmodule
